// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state type and width helpers for the FIFO burst-drain engine.
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } drain_state_e;

    // Width of a counter that must hold the value n itself (0..n).
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // Unsigned minimum, evaluated at full integer width before the caller truncates.
    function automatic int unsigned min_count(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_timeout_timer.sv
// burst_timeout_timer: counts idle cycles while a partial burst is waiting in the
// FIFO and flags when the wait has lasted TIMEOUT_CYCLES cycles. Saturates at the
// hit value so the flag stays up until the drain engine starts a burst.
module burst_timeout_timer
    import fifo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic run_i,
    output logic timeout_hit_o
);

    localparam int unsigned TW = count_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] HIT_VAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: count up while running, hold at the hit value, otherwise restart.
    always_comb begin
        timer_d = '0;
        if (run_i) begin
            timer_d = (timer_q == HIT_VAL) ? timer_q : timer_q + TW'(1);
        end
    end

    // Timer register with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout_hit_o = (timer_q == HIT_VAL);

endmodule

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains a first-word-fall-through sync FIFO towards a
// valid/ready consumer in bursts of at most BURST_LEN beats.
// Optional idle timeout (forces a partial burst) is enabled by defining the
// macro FIFO_BURST_DRAIN_TIMEOUT_EN; without it partial bursts need flush.
//
// state | meaning
// IDLE  | no burst; watch fifo_count for a full burst, flush or timeout
// BURST | pass-through of len_q beats from FIFO to consumer
module fifo_burst_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 256,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         fifo_valid,
    output logic                         fifo_ready,
    input  logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(BURST_LEN):0]   out_len,
    input  logic                         flush,
    input  logic                         clear,
    output logic                         busy
);

    localparam int unsigned CNT_W = count_width(FIFO_DEPTH);
    localparam int unsigned LEN_W = count_width(BURST_LEN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

    drain_state_e   state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             timeout_hit;
    logic             start_full;
    logic             start_part;
    logic             abort;
    logic [LEN_W-1:0] start_len;
    logic [LEN_W-1:0] last_idx;

    // A clear or reset cycle must not pop the FIFO or present a beat: the
    // registers are about to forget the burst, so any word taken now would be lost.
    assign abort      = clear | ~rstn;
    assign start_full = (fifo_count >= FULL_CNT);
    assign start_part = (flush | timeout_hit) & (fifo_count != '0);
    assign start_len  = LEN_W'(min_count(32'(fifo_count), BURST_LEN));
    assign last_idx   = len_q - LEN_W'(1);

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    logic timer_run;

    assign timer_run = (state_q == IDLE) && (fifo_count != '0) && (fifo_count < FULL_CNT);

    burst_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk           (clk),
        .rstn          (rstn),
        .clear_i       (clear),
        .run_i         (timer_run),
        .timeout_hit_o (timeout_hit)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // Next-state, burst bookkeeping and the combinational pass-through datapath.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        out_data   = fifo_data;
        out_valid  = 1'b0;
        fifo_ready = 1'b0;
        out_last   = 1'b0;
        out_len    = '0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_full || start_part) begin
                    len_d      = start_len;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            BURST: begin
                busy       = 1'b1;
                out_len    = len_q;
                out_valid  = fifo_valid & ~abort;
                fifo_ready = out_ready & ~abort;
                out_last   = out_valid & (beat_cnt_q == last_idx);
                if (out_valid && out_ready) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and burst registers; clear has the same effect as reset.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: drives fifo_burst_drain from a small FWFT sync FIFO and
// compares every cycle against a queue-based reference of the draining rules.
module tb_fifo_burst_drain;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BL    = 4;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rstn, clear, flush, out_ready;
    logic       push_en, fifo_clr;
    logic [7:0] push_data;

    logic [DW-1:0] fifo_data, out_data;
    logic          fifo_valid, fifo_ready, out_valid, out_last, busy;
    logic [4:0]    fifo_count;
    logic [2:0]    out_len;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .BURST_LEN      (BL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .fifo_count (fifo_count),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_len    (out_len),
        .flush      (flush),
        .clear      (clear),
        .busy       (busy)
    );

    // Upstream first-word-fall-through FIFO.
    logic [7:0] fmem [DEPTH];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic       f_push, f_pop;

    assign f_pop      = fifo_ready && (fcnt != 5'd0);
    assign f_push     = push_en && (fcnt != 5'(DEPTH));
    assign fifo_data  = fmem[rp];
    assign fifo_valid = (fcnt != 5'd0);
    assign fifo_count = fcnt;

    always_ff @(posedge clk) begin
        if (fifo_clr) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (f_push) begin
                fmem[wp] <= push_data;
                wp       <= wp + 4'd1;
            end
            if (f_pop) rp <= rp + 4'd1;
            fcnt <= fcnt + 5'(f_push) - 5'(f_pop);
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int last;
        int len;
        int cyc;
    } beat_t;
    beat_t blog[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: FIFO contents as a queue plus burst bookkeeping.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    int         m_len  = 0;
    int         m_done = 0;
    int         m_tmr  = 0;

    initial begin
        int  sz;
        bit  ab, hit, start;
        bit  e_valid, e_ready, e_last;
        forever begin
            @(posedge clk);
            sz = mq.size();
            ab = clear || !rstn;
            if (ab) begin
                m_busy = 1'b0;
                m_done = 0;
                m_len  = 0;
                m_tmr  = 0;
            end else if (m_busy) begin
                m_tmr = 0;
                if (out_ready && sz > 0) begin
                    void'(mq.pop_front());
                    if (m_done == m_len - 1) m_busy = 1'b0;
                    m_done++;
                end
            end else begin
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
                hit = (m_tmr == TO - 1);
                if (sz > 0 && sz < BL) m_tmr = (m_tmr == TO - 1) ? m_tmr : m_tmr + 1;
                else m_tmr = 0;
`else
                hit = 1'b0;
`endif
                start = (sz >= BL) || ((flush || hit) && sz != 0);
                if (start) begin
                    m_busy = 1'b1;
                    m_len  = (sz < BL) ? sz : BL;
                    m_done = 0;
                end
            end
            if (push_en && sz < DEPTH) mq.push_back(push_data);
            if (fifo_clr) mq.delete();

            @(negedge clk);
            ab      = clear || !rstn;
            e_valid = m_busy && mq.size() > 0 && !ab;
            e_ready = m_busy && out_ready && !ab;
            e_last  = e_valid && (m_done == m_len - 1);
            chk("busy", int'(busy), int'(m_busy));
            chk("out_valid", int'(out_valid), int'(e_valid));
            chk("fifo_ready", int'(fifo_ready), int'(e_ready));
            chk("out_last", int'(out_last), int'(e_last));
            chk("out_len", int'(out_len), m_busy ? m_len : 0);
            chk("fifo_count", int'(fifo_count), mq.size());
            if (e_valid) chk("out_data", int'(out_data), int'(mq[0]));
            if (out_valid && out_ready)
                blog.push_back('{int'(out_data), int'(out_last), int'(out_len), cyc});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + 8'(i);
            tick();
        end
        push_en = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int limit);
        int n = 0;
        while ((busy || fcnt != 0) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy || fcnt != 0) begin
            errors++;
            $display("FAIL %s: not drained after %0d cycles (busy %0d count %0d)", name, limit, busy, fcnt);
        end
    endtask

    task automatic wait_busy(input string name, input int limit);
        int n = 0;
        while (!busy && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (!busy) begin
            errors++;
            $display("FAIL %s: no burst started within %0d cycles", name, limit);
        end
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        flush     = 1'b1;
        wait_quiet(name, 300);
        flush = 1'b0;
    endtask

    initial begin
        int first_cnt, first_busy;
        int pat [4] = '{1, 0, 0, 1};

        rstn = 1'b0; clear = 1'b0; flush = 1'b0; out_ready = 1'b0;
        push_en = 1'b0; push_data = '0; fifo_clr = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_len", int'(out_len), 0);
        chk("rst_ready", int'(fifo_ready), 0);
        @(posedge clk); #1;
        rstn = 1'b1; fifo_clr = 1'b0;
        tick(2);

        // Two full bursts with a bubble between them.
        blog.delete();
        out_ready = 1'b1;
        push_seq(8'h10, 8);
        wait_quiet("t1_drain", 100);
        chk("t1_beats", blog.size(), 8);
        if (blog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t1_data", blog[i].d, 'h10 + i);
                chk("t1_last", blog[i].last, (i == 3 || i == 7) ? 1 : 0);
                chk("t1_len", blog[i].len, 4);
            end
            chk("t1_bubble", blog[4].cyc - blog[3].cyc, 2);
        end
        tick(2);

        // Flush-forced partial burst.
        blog.delete();
        push_seq(8'hA0, 2);
        tick(3);
        chk("t2_nostart", int'(busy), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_quiet("t2_drain", 50);
        chk("t2_beats", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("t2_d0", blog[0].d, 'hA0);
            chk("t2_last0", blog[0].last, 0);
            chk("t2_d1", blog[1].d, 'hA1);
            chk("t2_last1", blog[1].last, 1);
            chk("t2_len", blog[1].len, 2);
        end
        chk("t2_count", int'(fcnt), 0);
        tick(2);

        // Consumer back-pressure 1,0,0,1.
        blog.delete();
        out_ready = 1'b0;
        push_seq(8'hB0, 4);
        for (int i = 0; i < 20; i++) begin
            out_ready = pat[i % 4][0];
            tick();
        end
        out_ready = 1'b1;
        wait_quiet("t3_drain", 50);
        chk("t3_beats", blog.size(), 4);
        if (blog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_data", blog[i].d, 'hB0 + i);
                chk("t3_last", blog[i].last, (i == 3) ? 1 : 0);
            end
        end
        tick(2);

        // Clear on the second beat of a burst.
        out_ready = 1'b0;
        push_seq(8'hC0, 4);
        wait_busy("t4_start", 20);
        out_ready = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_valid", int'(out_valid), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_len", int'(out_len), 0);
        @(posedge clk); #1;
        blog.delete();
        out_ready = 1'b1;
        push_seq(8'hD0, 4);
        drain("t4_drain");
        chk("t4_beats", blog.size(), 7);
        if (blog.size() >= 4) begin
            chk("t4_first", blog[0].d, 'hC1);
            chk("t4_newlen", blog[0].len, 4);
            chk("t4_last3", blog[3].last, 1);
        end
        tick(2);

        // Three words and no flush: only the idle timeout may start a burst.
        blog.delete();
        out_ready = 1'b1;
        first_cnt = -1;
        first_busy = -1;
        for (int k = 0; k < 100; k++) begin
            push_en   = (k < 3);
            push_data = 8'hE0 + 8'(k);
            @(negedge clk);
            if (fcnt != 0 && first_cnt < 0) first_cnt = k;
            if (busy && first_busy < 0) first_busy = k;
            @(posedge clk); #1;
        end
        push_en = 1'b0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
        chk("t5_delay", first_busy - first_cnt, 8);
        chk("t5_beats", blog.size(), 3);
        if (blog.size() == 3) chk("t5_len", blog[2].len, 3);
`else
        chk("t5_noburst", first_busy, -1);
        chk("t5_nobeats", blog.size(), 0);
        drain("t5_drain");
`endif
        tick(2);

        // Reset pulse in the middle of a burst.
        out_ready = 1'b0;
        push_seq(8'hF0, 4);
        wait_busy("t6_start", 20);
        out_ready = 1'b1;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_len", int'(out_len), 0);
        chk("t6_ready", int'(fifo_ready), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_quiet", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        drain("t6_drain");
        tick(2);

        // Randomized traffic; the per-cycle reference carries the checking.
        for (int i = 0; i < 1500; i++) begin
            push_en   = ($urandom_range(0, 99) < 40);
            push_data = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 5);
            clear     = ($urandom_range(0, 99) < 1);
            rstn      = !($urandom_range(0, 199) < 1);
            tick();
        end
        push_en = 1'b0; clear = 1'b0; rstn = 1'b1;
        drain("rand_drain");
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
